// File: rtl/stream_mux_rr_if.sv
// Stream bundle between NCH producer channels, the multiplexer and one consumer.
// master = the side that drives the producer channels and the consumer ready.
interface stream_mux_rr_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic                  en;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [NCH*WIDTH-1:0]  in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output en,
    output mode,
    output sel,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  en,
    input  mode,
    input  sel,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/stream_mux_rr.sv
// NCH-channel stream multiplexer with fixed-select or round-robin grant and a
// single registered output stage; dbg_ptr exposes the round-robin pointer.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus,
  output logic [SELW-1:0] dbg_ptr
);

  // Handshake: a beat moves on a channel exactly when valid and ready are both
  // high at a rising edge. in_ready is combinational, never depends on the
  // same channel's in_valid in mode 0, and at most one bit is high. out_valid
  // and out_data only change at an edge; out_data is 0 whenever out_valid=0.

  logic [SELW-1:0]   ptr_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SELW-1:0]   out_ch_q;

  logic              load_ok;
  logic              grant_vld;
  logic [SELW-1:0]   grant_idx;
  logic [NCH-1:0]    ready_int;
  logic              xfer;
  logic [WIDTH-1:0]  grant_data;
  logic [SELW-1:0]   ptr_next;

  logic [2*NCH-1:0]  valid_dbl;
  logic [NCH-1:0]    valid_rot;
  logic [SELW:0]     rr_sum;
  logic [SELW:0]     ptr_sum;

  assign load_ok = bus.en & (~out_valid_q | bus.out_ready);

  // Rotate the valid vector so bit 0 is the channel at ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  always_comb begin
    valid_dbl = {bus.in_valid, bus.in_valid} >> ptr_q;
    valid_rot = valid_dbl[NCH-1:0];
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    if (!bus.mode) begin
      if ({1'b0, bus.sel} < (SELW+1)'(NCH)) begin
        grant_vld = 1'b1;
        grant_idx = bus.sel;
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (valid_rot[i]) begin
          grant_vld = 1'b1;
          rr_sum    = {1'b0, ptr_q} + (SELW+1)'(i);
          if (rr_sum >= (SELW+1)'(NCH)) begin
            rr_sum = rr_sum - (SELW+1)'(NCH);
          end
          grant_idx = rr_sum[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    ready_int = '0;
    for (int k = 0; k < NCH; k++) begin
      ready_int[k] = ~rst & grant_vld & load_ok & (grant_idx == SELW'(k));
    end
  end

  assign xfer = |(ready_int & bus.in_valid);

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_idx == SELW'(k)) begin
        grant_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, grant_idx} + (SELW+1)'(1);
    if (ptr_sum >= (SELW+1)'(NCH)) begin
      ptr_next = '0;
    end else begin
      ptr_next = ptr_sum[SELW-1:0];
    end
  end

  // A load takes priority over a drain so back-to-back beats leave no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_ch_q    <= grant_idx;
      if (bus.mode) begin
        ptr_q <= ptr_next;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a reference model plus an expected-beat
// queue filled on each input transfer and drained when the beat appears.
module tb_stream_mux_rr;
  localparam int WIDTH = 4;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [SELW-1:0] dbg_ptr;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .dbg_ptr (dbg_ptr)
  );

  int checks = 0;
  int errors = 0;

  logic [SELW+WIDTH-1:0] exp_q[$];
  logic [SELW-1:0]       ch_log[$];

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SELW-1:0]  m_ch;
  logic [SELW-1:0]  m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (!bus.mode) begin
      return (int'(bus.sel) < NCH) ? int'(bus.sel) : -1;
    end
    for (int i = 0; i < NCH; i++) begin
      int k;
      k = (int'(m_ptr) + i) % NCH;
      if (bus.in_valid[SELW'(k)]) return k;
    end
    return -1;
  endfunction

  // One clock: check combinational ready, predict the transfer, then check
  // the registered outputs after the edge.
  task automatic cycle(input string tag);
    int g;
    logic lok, xfer, mode_s, ordy_s, rst_s;
    logic [NCH-1:0] exp_rdy;
    logic [NCH*WIDTH-1:0] shifted;
    logic [SELW+WIDTH-1:0] beat;
    #1;
    rst_s  = rst;
    mode_s = bus.mode;
    ordy_s = bus.out_ready;
    lok = bus.en && (!m_valid || bus.out_ready);
    g = model_grant();
    exp_rdy = '0;
    if (!rst && g >= 0 && lok) exp_rdy[SELW'(g)] = 1'b1;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    xfer = !rst && g >= 0 && lok && bus.in_valid[SELW'(g)];
    if (xfer) begin
      shifted = bus.in_data >> (g * WIDTH);
      exp_q.push_back({SELW'(g), shifted[WIDTH-1:0]});
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = '0;
    end else if (xfer) begin
      beat = exp_q.pop_front();
      {m_ch, m_data} = beat;
      m_valid = 1'b1;
      ch_log.push_back(m_ch);
      if (mode_s) m_ptr = (g == NCH - 1) ? '0 : SELW'(g + 1);
    end else if (m_valid && ordy_s) begin
      m_valid = 1'b0;
      m_data  = '0;
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, " out_data"},  32'(bus.out_data),  32'(m_data));
    check({tag, " out_ch"},    32'(bus.out_ch),    32'(m_ch));
    check({tag, " ptr"},       32'(dbg_ptr),       32'(m_ptr));
  endtask

  function automatic logic [NCH*WIDTH-1:0] rand_data();
    logic [NCH*WIDTH-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    return d;
  endfunction

  initial begin
    m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = '0;
    rst = 1'b1;
    bus.en = 1'b1; bus.mode = 1'b0; bus.sel = '0;
    bus.in_data = rand_data(); bus.in_valid = '1; bus.out_ready = 1'b1;

    // Reset with every channel valid: no ready may leak out.
    cycle("rst0");
    cycle("rst1");
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    check("rst ptr",       32'(dbg_ptr),       32'd0);

    rst = 1'b0;
    bus.in_valid = '0;
    cycle("idle");

    // Fixed select of channel 2.
    bus.sel = 2'd2; bus.in_data = 16'h3A51; bus.in_valid = '1;
    cycle("m0a");
    check("m0 data A", 32'(bus.out_data), 32'hA);
    check("m0 ch 2",   32'(bus.out_ch),   32'd2);
    bus.in_data = rand_data();
    cycle("m0b");
    cycle("m0c");
    // Ready on the selected channel even when it is not valid.
    bus.sel = 2'd1; bus.in_valid = 4'b0000;
    cycle("m0 novalid");

    // Round robin, all channels valid.
    bus.mode = 1'b1; bus.in_valid = '1;
    ch_log.delete();
    for (int i = 0; i < 6; i++) begin
      bus.in_data = rand_data();
      cycle("rr all");
    end
    check("rr all count", 32'(ch_log.size()), 32'd6);
    if (ch_log.size() == 6) begin
      check("rr seq0", 32'(ch_log[0]), 32'd0);
      check("rr seq1", 32'(ch_log[1]), 32'd1);
      check("rr seq2", 32'(ch_log[2]), 32'd2);
      check("rr seq3", 32'(ch_log[3]), 32'd3);
      check("rr seq4", 32'(ch_log[4]), 32'd0);
      check("rr seq5", 32'(ch_log[5]), 32'd1);
    end

    // One ch0 beat moves ptr to 1, then ch1/ch3 alternate.
    bus.in_valid = 4'b0001;
    cycle("rr ch0");
    bus.in_valid = 4'b1010;
    ch_log.delete();
    for (int i = 0; i < 4; i++) begin
      bus.in_data = rand_data();
      cycle("rr 13");
    end
    check("rr13 count", 32'(ch_log.size()), 32'd4);
    if (ch_log.size() == 4) begin
      check("rr13 seq0", 32'(ch_log[0]), 32'd1);
      check("rr13 seq1", 32'(ch_log[1]), 32'd3);
      check("rr13 seq2", 32'(ch_log[2]), 32'd1);
      check("rr13 seq3", 32'(ch_log[3]), 32'd3);
    end

    // Backpressure: held beat stays put, then drain and load in one cycle.
    bus.out_ready = 1'b0; bus.in_valid = '1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = rand_data();
      cycle("stall");
    end
    bus.out_ready = 1'b1; bus.in_valid = 4'b0001;
    cycle("unstall");
    check("unstall valid", 32'(bus.out_valid), 32'd1);
    check("unstall ch0",   32'(bus.out_ch),    32'd0);

    // en=0: held beat drains, nothing new loads, then resume from ptr.
    bus.out_ready = 1'b0; bus.in_valid = '1;
    cycle("hold");
    bus.en = 1'b0; bus.out_ready = 1'b1;
    cycle("en0 drain");
    check("en0 drained", 32'(bus.out_valid), 32'd0);
    check("en0 data0",   32'(bus.out_data),  32'd0);
    cycle("en0 idle");
    bus.en = 1'b1;
    cycle("en1 resume");
    check("resume ch1", 32'(bus.out_ch), 32'd1);

    // Reset while a transfer would otherwise happen.
    rst = 1'b1;
    cycle("midrst");
    check("midrst valid", 32'(bus.out_valid), 32'd0);
    check("midrst ptr",   32'(dbg_ptr),       32'd0);
    rst = 1'b0;
    cycle("post rst");
    check("post rst ch0", 32'(bus.out_ch), 32'd0);

    check("queue empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
